// File: rtl/reply_arbiter.sv
// reply_arbiter: round-robin arbiter framing source replies as len, id, payload into the outbound FIFO.
// Define REPLY_ARB_FIXED_PRIO_EN for fixed priority (lowest req index wins, ptr held at 0).
module reply_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] len,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_ack,
  output logic [N_SRC-1:0]   grant,
  input  logic               out_full,
  output logic               out_wr,
  output logic [7:0]         out_data,
  output logic               busy
);
  localparam int PW = $clog2(N_SRC);
  typedef enum logic [2:0] {IDLE, HDR_LEN, HDR_ID, PAYLOAD, GAP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [7:0] len_q, len_d, sent_q, sent_d, len_sel, data_sel;
  logic [2:0] id_q, id_d, sel;
  logic hit;
  // Scan from the highest offset down so the first set bit at or after ptr wins.
  always_comb begin
    int j;
    j = 0;
    sel = '0;
    hit = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % N_SRC;
      if (req[j]) begin
        hit = 1'b1;
        sel = 3'(j);
      end
    end
  end
  always_comb begin
    len_sel = '0;
    data_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == 3'(i)) len_sel = len[8*i +: 8];
      if (id_q == 3'(i)) data_sel = src_data[8*i +: 8];
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    len_d = len_q;
    sent_d = sent_q;
    id_d = id_q;
    out_wr = 1'b0;
    out_data = '0;
    src_ack = '0;
    case (state_q)
      IDLE: if (hit) begin
        state_d = HDR_LEN;
        grant_d = N_SRC'(1) << sel;
        len_d = len_sel;
        id_d = sel;
        sent_d = '0;
      end
      HDR_LEN: begin
        out_wr = ~out_full;
        out_data = len_q;
        state_d = out_wr ? HDR_ID : state_q;
      end
      HDR_ID: begin
        out_wr = ~out_full;
        out_data = {5'b0, id_q};
        state_d = !out_wr ? state_q : (len_q != 8'd0) ? PAYLOAD : GAP;
      end
      PAYLOAD: begin
        out_wr = ~out_full;
        out_data = data_sel;
        src_ack = out_wr ? grant_q : '0;
        sent_d = out_wr ? sent_q + 8'd1 : sent_q;
        state_d = (out_wr && sent_q == len_q - 8'd1) ? GAP : state_q;
      end
      GAP: begin
        state_d = IDLE;
        grant_d = '0;
`ifdef REPLY_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = PW'((int'(id_q) + 1) % N_SRC);
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      len_q <= '0;
      sent_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      len_q <= len_d;
      sent_q <= sent_d;
      id_q <= id_d;
    end
  end
  assign grant = grant_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_reply_arbiter.sv
// tb_reply_arbiter: scoreboard bench; tests queue expected bytes, a negedge monitor pops and compares.
module tb_reply_arbiter;
  logic clk = 1'b0, reset_n = 1'b0, out_full = 1'b0, out_wr, busy;
  logic [3:0] req = '0, src_ack, grant;
  logic [31:0] len = '0, src_data;
  logic [7:0] out_data;
  int checks = 0, errors = 0, wr_cnt = 0, ack_cnt = 0, busy_cyc = 0;
  typedef struct packed {logic [7:0] d; logic [3:0] a;} exp_t;
  exp_t q[$];
  logic [7:0] mem[4][16];
  int popped[4] = '{default: 0};
  int base[4] = '{default: 0};

  always #5 clk = ~clk;

  reply_arbiter #(.N_SRC(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .len(len), .src_data(src_data),
    .src_ack(src_ack), .grant(grant), .out_full(out_full), .out_wr(out_wr),
    .out_data(out_data), .busy(busy)
  );

  // FWFT source model: each ack pops one byte
  always @(posedge clk) for (int i = 0; i < 4; i++) if (src_ack[i]) popped[i] <= popped[i] + 1;
  always_comb for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = mem[i][4'(popped[i] - base[i])];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push(logic [7:0] d, logic [3:0] a);
    q.push_back('{d: d, a: a});
  endfunction

  always @(negedge clk) if (reset_n) begin
    if (busy) busy_cyc++;
    if (out_full) chk("stall_wr", 32'(out_wr), 32'd0);
    if (out_wr === 1'b1) begin
      wr_cnt++;
      if (|src_ack) ack_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got %0h expected no write", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("src_ack", 32'(src_ack), 32'(e.a));
      end
    end else if (src_ack !== 4'b0) chk("ack_no_wr", 32'(src_ack), 32'd0);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr;
    wr_cnt = 0;
    ack_cnt = 0;
    busy_cyc = 0;
  endtask

  task automatic load(int s, logic [7:0] l, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                      logic [7:0] b3, logic [7:0] b4);
    mem[s][0] = b0; mem[s][1] = b1; mem[s][2] = b2; mem[s][3] = b3; mem[s][4] = b4;
    base[s] = popped[s];
    len[s*8 +: 8] = l;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    q.delete();
    tick;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (busy && n < 400) begin
      tick;
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 400), 32'd1);
    chk({nm, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_wr(string nm, int target);
    int n = 0;
    while (wr_cnt < target && n < 200) begin
      tick;
      n++;
    end
    chk({nm, "_wr_reached"}, 32'(wr_cnt >= target), 32'd1);
  endtask

  initial begin
    int g, n;
    logic [3:0] prev;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_ack", 32'(src_ack), 32'd0);

    // single source, three payload bytes
    clr;
    load(1, 8'd3, 8'hA1, 8'hA2, 8'hA3, 8'hEE, 8'hEE);
    push(8'h03, 4'b0); push(8'h01, 4'b0);
    push(8'hA1, 4'b0010); push(8'hA2, 4'b0010); push(8'hA3, 4'b0010);
    req = 4'b0010;
    tick;
    chk("t1_grant", 32'(grant), 32'b0010);
    req = '0;
    wait_done("t1");
    chk("t1_writes", 32'(wr_cnt), 32'd5);
    chk("t1_acks", 32'(ack_cnt), 32'd3);
    chk("t1_busy_cycles", 32'(busy_cyc), 32'd6);

    // zero length
    clr;
    load(0, 8'd0, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    push(8'h00, 4'b0); push(8'h00, 4'b0);
    req = 4'b0001;
    tick;
    req = '0;
    wait_done("t2");
    chk("t2_writes", 32'(wr_cnt), 32'd2);
    chk("t2_acks", 32'(ack_cnt), 32'd0);
    chk("t2_busy_cycles", 32'(busy_cyc), 32'd3);

    // round-robin from ptr 0
    do_reset;
    clr;
    load(0, 8'd1, 8'hB0, 8'hB4, 8'hEE, 8'hEE, 8'hEE);
    load(1, 8'd1, 8'hB1, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    load(2, 8'd1, 8'hB2, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    load(3, 8'd1, 8'hB3, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    foreach (mem[i]) begin end
    push(8'h01, 4'b0); push(8'h00, 4'b0); push(8'hB0, 4'b0001);
    push(8'h01, 4'b0); push(8'h01, 4'b0); push(8'hB1, 4'b0010);
    push(8'h01, 4'b0); push(8'h02, 4'b0); push(8'hB2, 4'b0100);
    push(8'h01, 4'b0); push(8'h03, 4'b0); push(8'hB3, 4'b1000);
    push(8'h01, 4'b0); push(8'h00, 4'b0); push(8'hB4, 4'b0001);
    req = 4'hF;
    g = 0;
    n = 0;
    prev = '0;
    while (g < 5 && n < 200) begin
      tick;
      n++;
      if (grant != 4'b0 && prev == 4'b0) g++;
      prev = grant;
    end
    req = '0;
    chk("t3_grants", 32'(g), 32'd5);
    wait_done("t3");
    chk("t3_writes", 32'(wr_cnt), 32'd15);

    // backpressure after the 2nd payload byte
    clr;
    load(2, 8'd4, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hEE);
    push(8'h04, 4'b0); push(8'h02, 4'b0);
    push(8'hC1, 4'b0100); push(8'hC2, 4'b0100); push(8'hC3, 4'b0100); push(8'hC4, 4'b0100);
    req = 4'b0100;
    tick;
    req = '0;
    wait_wr("t4", 4);
    @(posedge clk);
    #1;
    out_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_full = 1'b0;
    tick;
    wait_done("t4");
    chk("t4_writes", 32'(wr_cnt), 32'd6);
    chk("t4_acks", 32'(ack_cnt), 32'd4);

    // req drop and len change after grant are ignored
    clr;
    load(2, 8'd2, 8'hD1, 8'hD2, 8'hEE, 8'hEE, 8'hEE);
    push(8'h02, 4'b0); push(8'h02, 4'b0); push(8'hD1, 4'b0100); push(8'hD2, 4'b0100);
    req = 4'b0100;
    tick;
    chk("t5_grant", 32'(grant), 32'b0100);
    req = '0;
    len[23:16] = 8'd9;
    wait_done("t5");
    chk("t5_writes", 32'(wr_cnt), 32'd4);
    chk("t5_acks", 32'(ack_cnt), 32'd2);

    // reset during the 2nd payload byte
    do_reset;
    clr;
    load(1, 8'd5, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5);
    push(8'h05, 4'b0); push(8'h01, 4'b0); push(8'hF1, 4'b0010); push(8'hF2, 4'b0010);
    req = 4'b0010;
    tick;
    req = '0;
    wait_wr("t6", 4);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out_wr", 32'(out_wr), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_src_ack", 32'(src_ack), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_queue", 32'(q.size()), 32'd0);
    q.delete();
    tick;
    tick;
    clr;
    load(3, 8'd1, 8'h5A, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    push(8'h01, 4'b0); push(8'h03, 4'b0); push(8'h5A, 4'b1000);
    req = 4'b1000;
    reset_n = 1'b1;
    tick;
    chk("t6_grant", 32'(grant), 32'b1000);
    req = '0;
    wait_done("t6");
    chk("t6_writes", 32'(wr_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
